// File: rtl/vga_dma_pkg.sv
// Shared types and default dimensions for the frame-buffer write address generator.
package vga_dma_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    AUTO  = 1'b0,
    FIXED = 1'b1
  } mode_e;

  localparam int DEF_IMG_W     = 256;
  localparam int DEF_IMG_H     = 256;
  localparam int DEF_FB_W      = 512;
  localparam int DEF_FB_H      = 256;
  localparam int DEF_NUM_SLOTS = 2;

  // $clog2 with a floor of one bit, so degenerate sizes still get a real vector.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/vga_xy_cnt.sv
// Raster x/y counter for one image: flags the end of a row and the last pixel of the frame.
module vga_xy_cnt
  import vga_dma_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic adv_i,
  output logic row_end_o,
  output logic last_o
);

  localparam int XW = clog2_min1(IMG_W);
  localparam int YW = clog2_min1(IMG_H);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  assign row_end_o = (x_q == XW'(IMG_W - 1));
  assign last_o    = row_end_o && (y_q == YW'(IMG_H - 1));

  // Clear wins over advance: a restart discards the pixel position in the same cycle.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (adv_i) begin
      if (!row_end_o) begin
        x_d = x_q + 1'b1;
      end else begin
        x_d = '0;
        y_d = last_o ? '0 : y_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/vga_wr_agen.sv
// Frame-buffer write address generator: maps a coprocessor pixel stream into one of
// several horizontally adjacent image slots, with AUTO round-robin or FIXED slot choice.
module vga_wr_agen
  import vga_dma_pkg::*;
#(
  parameter  int IMG_W     = DEF_IMG_W,
  parameter  int IMG_H     = DEF_IMG_H,
  parameter  int FB_W      = DEF_FB_W,
  parameter  int FB_H      = DEF_FB_H,
  parameter  int NUM_SLOTS = DEF_NUM_SLOTS,
  localparam int ADDR_W    = $clog2(FB_W * FB_H),
  localparam int SLOT_W    = clog2_min1(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [SLOT_W-1:0] slot_sel,
  input  logic              slot_clr,
  input  logic              we_in,
  output logic [ADDR_W-1:0] waddr,
  output logic              we_out,
  output logic              busy,
  output logic              frame_done,
  output logic [SLOT_W-1:0] slot_cur,
  output logic              ovf
);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [SLOT_W-1:0] ptr_q, ptr_d;
  logic [SLOT_W-1:0] slot_cur_q, slot_cur_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic              row_end;
  logic              last_px;
  logic [SLOT_W-1:0] ptr_nx;
  logic [SLOT_W-1:0] sel_clamped;
  logic [SLOT_W-1:0] start_slot;

  assign we_out = we_in && (state_q == RUN);

  vga_xy_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_xy (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (start),
    .adv_i     (we_out),
    .row_end_o (row_end),
    .last_o    (last_px)
  );

  assign ptr_nx = (ptr_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : ptr_q + 1'b1;

  always_comb begin
    sel_clamped = slot_sel;
    if (int'(slot_sel) > NUM_SLOTS - 1) begin
      sel_clamped = SLOT_W'(NUM_SLOTS - 1);
    end
  end

  // Completion is resolved before start so a coincident start sees the advanced pointer.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    waddr_d    = waddr_q;
    ptr_d      = ptr_q;
    slot_cur_d = slot_cur_q;
    ovf_d      = ovf_q;
    done_d     = we_out && last_px;
    start_slot = '0;

    case (state_q)
      IDLE: begin
        if (we_in) begin
          ovf_d = 1'b1;
        end
      end
      RUN: begin
        if (we_out) begin
          if (last_px) begin
            state_d = IDLE;
            if (mode_q == AUTO) begin
              ptr_d = ptr_nx;
            end
          end else if (row_end) begin
            waddr_d = waddr_q + ADDR_W'(FB_W - IMG_W + 1);
          end else begin
            waddr_d = waddr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (slot_clr) begin
      ptr_d = '0;
    end

    if (start) begin
      start_slot = (mode_e'(mode) == FIXED) ? sel_clamped : ptr_d;
      state_d    = RUN;
      mode_d     = mode_e'(mode);
      waddr_d    = ADDR_W'(start_slot) * ADDR_W'(IMG_W);
      slot_cur_d = start_slot;
      ovf_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= AUTO;
      waddr_q    <= '0;
      ptr_q      <= '0;
      slot_cur_q <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      waddr_q    <= waddr_d;
      ptr_q      <= ptr_d;
      slot_cur_q <= slot_cur_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign waddr      = waddr_q;
  assign busy       = (state_q == RUN);
  assign frame_done = done_q;
  assign slot_cur   = slot_cur_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_vga_wr_agen.sv
// Bench for vga_wr_agen: a default-size instance and a 3x2 instance, each tracked by a
// pixel-index model that derives addresses as slot*W + row*FB_W + column.
module tb_vga_wr_agen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        a_rst_n = 1'b0, a_start = 1'b0, a_mode = 1'b0, a_sel = 1'b0, a_clr = 1'b0, a_we = 1'b0;
  logic [16:0] a_waddr;
  logic        a_we_out, a_busy, a_fd, a_slot, a_ovf;

  // Instance B: IMG_W=3, IMG_H=2, FB_W=8, NUM_SLOTS=2
  logic        b_rst_n = 1'b0, b_start = 1'b0, b_mode = 1'b0, b_sel = 1'b0, b_clr = 1'b0, b_we = 1'b0;
  logic [3:0]  b_waddr;
  logic        b_we_out, b_busy, b_fd, b_slot, b_ovf;

  vga_wr_agen u_a (
    .clk(clk), .rst_n(a_rst_n), .start(a_start), .mode(a_mode), .slot_sel(a_sel),
    .slot_clr(a_clr), .we_in(a_we), .waddr(a_waddr), .we_out(a_we_out), .busy(a_busy),
    .frame_done(a_fd), .slot_cur(a_slot), .ovf(a_ovf)
  );

  vga_wr_agen #(.IMG_W(3), .IMG_H(2), .FB_W(8), .FB_H(2), .NUM_SLOTS(2)) u_b (
    .clk(clk), .rst_n(b_rst_n), .start(b_start), .mode(b_mode), .slot_sel(b_sel),
    .slot_clr(b_clr), .we_in(b_we), .waddr(b_waddr), .we_out(b_we_out), .busy(b_busy),
    .frame_done(b_fd), .slot_cur(b_slot), .ovf(b_ovf)
  );

  typedef struct {
    bit run;
    int n;      // index of the next pixel within the frame
    int slot;
    int ptr;
    bit ovf;
    bit fd;
    bit fixed;
    int hold;   // address shown once a frame has completed
  } mdl_t;

  mdl_t ma = '{default: 0};
  mdl_t mb = '{default: 0};
  int checks = 0;
  int passes = 0;
  int a_fd_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  function automatic int pix_addr(input int slot, input int n, input int w, input int fbw);
    return slot * w + (n / w) * fbw + (n % w);
  endfunction

  function automatic mdl_t step(input mdl_t m, input bit st, input bit md, input int sel,
                                input bit clr, input bit we, input int w, input int h,
                                input int fbw, input int ns);
    mdl_t r = m;
    r.fd = 1'b0;
    if (m.run && we) begin
      if (m.n == w * h - 1) begin
        r.run  = 1'b0;
        r.fd   = 1'b1;
        r.hold = pix_addr(m.slot, m.n, w, fbw);
        if (!m.fixed) r.ptr = (m.ptr + 1) % ns;
      end else begin
        r.n = m.n + 1;
      end
    end
    if (!m.run && we) r.ovf = 1'b1;
    if (clr) r.ptr = 0;
    if (st) begin
      r.fixed = md;
      r.slot  = md ? ((sel > ns - 1) ? ns - 1 : sel) : r.ptr;
      r.run   = 1'b1;
      r.n     = 0;
      r.ovf   = 1'b0;
    end
    return r;
  endfunction

  always @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) ma = '{default: 0};
    else ma = step(ma, a_start, a_mode, int'(a_sel), a_clr, a_we, 256, 256, 512, 2);
  end

  always @(posedge clk or negedge b_rst_n) begin
    if (!b_rst_n) mb = '{default: 0};
    else mb = step(mb, b_start, b_mode, int'(b_sel), b_clr, b_we, 3, 2, 8, 2);
  end

  always @(negedge clk) begin
    chk("a_waddr", int'(a_waddr), ma.run ? pix_addr(ma.slot, ma.n, 256, 512) : ma.hold);
    chk("a_we_out", int'(a_we_out), int'(a_we && ma.run));
    chk("a_busy", int'(a_busy), int'(ma.run));
    chk("a_frame_done", int'(a_fd), int'(ma.fd));
    chk("a_slot_cur", int'(a_slot), ma.slot);
    chk("a_ovf", int'(a_ovf), int'(ma.ovf));
    chk("b_waddr", int'(b_waddr), mb.run ? pix_addr(mb.slot, mb.n, 3, 8) : mb.hold);
    chk("b_we_out", int'(b_we_out), int'(b_we && mb.run));
    chk("b_busy", int'(b_busy), int'(mb.run));
    chk("b_frame_done", int'(b_fd), int'(mb.fd));
    chk("b_slot_cur", int'(b_slot), mb.slot);
    chk("b_ovf", int'(b_ovf), int'(mb.ovf));
    if (a_fd) a_fd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stim_a();
    repeat (2) tick();
    a_rst_n = 1'b1;
    @(negedge clk);
    chk("a_rst_waddr", int'(a_waddr), 0);
    chk("a_rst_busy", int'(a_busy), 0);
    chk("a_rst_ovf", int'(a_ovf), 0);
    tick();
    // first AUTO frame, full size
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_we    = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      if (i == 0)     chk("a_f1_first", int'(a_waddr), 0);
      if (i == 255)   chk("a_f1_row0_end", int'(a_waddr), 255);
      if (i == 256)   chk("a_f1_row1_start", int'(a_waddr), 512);
      if (i == 65535) chk("a_f1_last", int'(a_waddr), 130815);
      tick();
    end
    a_we = 1'b0;
    @(negedge clk);
    chk("a_f1_done", int'(a_fd), 1);
    chk("a_f1_hold", int'(a_waddr), 130815);
    tick();
    tick();
    chk("a_f1_done_count", a_fd_cnt, 1);
    chk("a_f1_slot", int'(a_slot), 0);
    // stray pixel while idle
    a_we = 1'b1;
    @(negedge clk);
    chk("a_idle_we_out", int'(a_we_out), 0);
    tick();
    a_we = 1'b0;
    repeat (3) tick();
    chk("a_ovf_sticky", int'(a_ovf), 1);
    chk("a_idle_hold", int'(a_waddr), 130815);
    // second AUTO frame, aborted at pixel 1000
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("a_f2_first", int'(a_waddr), 256);
    chk("a_f2_ovf_clr", int'(a_ovf), 0);
    chk("a_f2_slot", int'(a_slot), 1);
    a_we = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 256) chk("a_f2_row1", int'(a_waddr), 768);
      tick();
    end
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_we    = 1'b0;
    @(negedge clk);
    chk("a_abort_base", int'(a_waddr), 256);
    chk("a_abort_no_done", int'(a_fd), 0);
    tick();
    // FIXED slot 1 twice, then slot 0, then AUTO still at pointer 1
    for (int k = 0; k < 3; k++) begin
      a_mode  = 1'b1;
      a_sel   = (k < 2) ? 1'b1 : 1'b0;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      a_we    = 1'b1;
      @(negedge clk);
      chk("a_fixed_base", int'(a_waddr), (k < 2) ? 256 : 0);
      repeat (20) tick();
      a_we = 1'b0;
    end
    a_mode  = 1'b0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("a_auto_after_fixed", int'(a_waddr), 256);
    // reset mid-frame
    a_we = 1'b1;
    repeat (5) tick();
    #2;
    a_rst_n = 1'b0;
    #1;
    chk("a_rst_mid_waddr", int'(a_waddr), 0);
    chk("a_rst_mid_we_out", int'(a_we_out), 0);
    chk("a_rst_mid_busy", int'(a_busy), 0);
    tick();
    a_we    = 1'b0;
    a_rst_n = 1'b1;
    repeat (3) tick();
    chk("a_rst_no_done", a_fd_cnt, 1);
  endtask

  task automatic stim_b();
    int seq0[6] = '{0, 1, 2, 8, 9, 10};
    int seq1[6] = '{3, 4, 5, 11, 12, 13};
    repeat (2) tick();
    b_rst_n = 1'b1;
    tick();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_we    = 1'b1;
    // start coincides with the last pixel of the slot 0 frame
    for (int i = 0; i < 6; i++) begin
      b_start = (i == 5);
      @(negedge clk);
      chk("b_seq0", int'(b_waddr), seq0[i]);
      tick();
    end
    b_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("b_coinc_done", int'(b_fd), 1);
        chk("b_coinc_slot", int'(b_slot), 1);
      end
      chk("b_seq1", int'(b_waddr), seq1[i]);
      tick();
    end
    b_we = 1'b0;
    @(negedge clk);
    chk("b_f2_done", int'(b_fd), 1);
    chk("b_f2_hold", int'(b_waddr), 13);
    tick();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("b_wrap_base", int'(b_waddr), 0);
    for (int i = 0; i < 4000; i++) begin
      tick();
      b_start = ($urandom_range(0, 15) == 0);
      b_mode  = 1'($urandom_range(0, 1));
      b_sel   = 1'($urandom_range(0, 1));
      b_clr   = ($urandom_range(0, 31) == 0);
      b_we    = ($urandom_range(0, 7) != 0);
      b_rst_n = ($urandom_range(0, 499) != 0);
    end
    tick();
    b_rst_n = 1'b1;
    b_start = 1'b0;
    b_we    = 1'b0;
    b_clr   = 1'b0;
  endtask

  initial begin
    fork
      stim_a();
      stim_b();
    join
    repeat (2) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
